// File: rtl/add_sub_serial_pkg.sv
// ----------------------------------------------------------------------------
// add_sub_serial_pkg
// Shared types and constants for the serial adder/subtractor.
//   state_e   : controller state (IDLE, ADD, DONE), 2-bit encoding
//   MODE_ADD  : value of 'sub' that selects a + b
//   MODE_SUB  : value of 'sub' that selects a - b
// ----------------------------------------------------------------------------
package add_sub_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage : add_sub_serial_pkg

// File: rtl/add_sub_serial_slice.sv
// ----------------------------------------------------------------------------
// add_sub_serial_slice
// Combinational STEP-bit ripple-carry adder used once per cycle by the
// serial datapath.
//   x, y  : in  STEP   slice operands
//   cin   : in  1      carry into bit 0
//   s     : out STEP   slice sum
//   cout  : out 1      carry out of the top bit
//   c_msb : out 1      carry into the top bit (needed for signed overflow)
// ----------------------------------------------------------------------------
module add_sub_serial_slice #(
    parameter int STEP = 1
) (
    input  logic [STEP-1:0] x,
    input  logic [STEP-1:0] y,
    input  logic            cin,
    output logic [STEP-1:0] s,
    output logic            cout,
    output logic            c_msb
);

    // c[i] is the carry into bit i; c[STEP] is the slice carry-out.
    logic [STEP:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < STEP; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign cout  = c[STEP];
    assign c_msb = c[STEP-1];

endmodule : add_sub_serial_slice

// File: rtl/add_sub_serial_param.sv
// ----------------------------------------------------------------------------
// add_sub_serial_param
// Serial adder/subtractor: latches two WIDTH-bit operands on a start request
// and processes STEP bits per cycle, LSB slice first, over N = WIDTH/STEP
// cycles. Reports result, carry-out and two's-complement overflow.
//   clk   : in  1      clock, rising edge
//   rst   : in  1      synchronous active-high reset
//   en    : in  1      start request, honoured in IDLE and DONE only
//   sub   : in  1      0 = a + b, 1 = a - b (latched on start)
//   a, b  : in  WIDTH  operands (latched on start)
//   out   : out WIDTH  result, valid while done = 1
//   cout  : out 1      final carry-out (subtract: 1 = no borrow)
//   ovf   : out 1      signed overflow
//   busy  : out 1      high while in ADD
//   done  : out 1      high while in DONE (result held)
// ----------------------------------------------------------------------------
module add_sub_serial_param
    import add_sub_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH < 2) || (STEP < 1) || ((WIDTH % STEP) != 0)) begin : g_param_check
            $error("add_sub_serial_param: WIDTH must be >= 2 and divisible by STEP");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [STEP-1:0]  slice_s;
    logic             slice_c;
    logic             slice_c_msb;
    logic             last_slice;

    add_sub_serial_slice #(
        .STEP (STEP)
    ) u_slice (
        .x     (a_q[STEP-1:0]),
        .y     (b_q[STEP-1:0]),
        .cin   (carry_q),
        .s     (slice_s),
        .cout  (slice_c),
        .c_msb (slice_c_msb)
    );

    assign last_slice = (count_q == CW'(N - 1));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (en) begin
                    // Subtraction is a + ~b + 1: invert B here and seed the
                    // ripple carry with 1.
                    state_d = ADD;
                    a_d     = a;
                    b_d     = (sub == MODE_SUB) ? ~b : b;
                    carry_d = (sub == MODE_SUB);
                    out_d   = '0;
                    count_d = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            ADD: begin
                // New slice enters at the top of out; after N shifts the
                // first slice has arrived at bit 0.
                out_d   = (out_q >> STEP) | (WIDTH'(slice_s) << (WIDTH - STEP));
                a_d     = a_q >> STEP;
                b_d     = b_q >> STEP;
                carry_d = slice_c;
                count_d = count_q + CW'(1);
                if (last_slice) begin
                    state_d = DONE;
                    cout_d  = slice_c;
                    ovf_d   = slice_c_msb ^ slice_c;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out  = out_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == ADD);
    assign done = (state_q == DONE);

endmodule : add_sub_serial_param

// File: tb/tb_add_sub_serial_param.sv
// ----------------------------------------------------------------------------
// tb_add_sub_serial_param
// Directed bench for add_sub_serial_param with three instances:
//   u8  : WIDTH=8,  STEP=1 (N=8)
//   u16 : WIDTH=16, STEP=4 (N=4)
//   u1  : WIDTH=8,  STEP=8 (N=1, registered full adder)
// ----------------------------------------------------------------------------
module tb_add_sub_serial_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 8-bit, 1 bit per cycle
    logic       en8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, out8;
    logic       cout8, ovf8, busy8, done8;

    // 16-bit, 4 bits per cycle
    logic        en16 = 1'b0, sub16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, out16;
    logic        cout16, ovf16, busy16, done16;

    // 8-bit, whole word per cycle
    logic       en1 = 1'b0, sub1 = 1'b0;
    logic [7:0] a1 = '0, b1 = '0, out1;
    logic       cout1, ovf1, busy1, done1;

    add_sub_serial_param #(.WIDTH(8), .STEP(1)) u8 (
        .clk(clk), .rst(rst), .en(en8), .sub(sub8), .a(a8), .b(b8),
        .out(out8), .cout(cout8), .ovf(ovf8), .busy(busy8), .done(done8)
    );

    add_sub_serial_param #(.WIDTH(16), .STEP(4)) u16 (
        .clk(clk), .rst(rst), .en(en16), .sub(sub16), .a(a16), .b(b16),
        .out(out16), .cout(cout16), .ovf(ovf16), .busy(busy16), .done(done16)
    );

    add_sub_serial_param #(.WIDTH(8), .STEP(8)) u1 (
        .clk(clk), .rst(rst), .en(en1), .sub(sub1), .a(a1), .b(b1),
        .out(out1), .cout(cout1), .ovf(ovf1), .busy(busy1), .done(done1)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       sub;
        logic [7:0] a;
        logic [7:0] b;
        logic       noise;   // pulse en with junk operands while busy
        logic [7:0] out;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One operation on the 8-bit/STEP=1 instance. en rises mid-cycle, the
    // next edge accepts, and 8 ADD edges later done is seen: 9 edges total.
    task automatic run8(input int idx, input vec_t v);
        int lat;
        @(negedge clk);
        en8 = 1'b1; sub8 = v.sub; a8 = v.a; b8 = v.b;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            sub8 = 1'($urandom);
            en8  = v.noise && (lat == 3 || lat == 5);
        end while (!done8 && lat < 40);
        en8 = 1'b0;
        $display("vec %0d: sub=%0b a=%02h b=%02h -> out=%02h cout=%0b ovf=%0b lat=%0d",
                 idx, v.sub, v.a, v.b, out8, cout8, ovf8, lat);
        check("lat8", lat, 9);
        check("out8", {24'd0, out8}, {24'd0, v.out});
        check("cout8", {31'd0, cout8}, {31'd0, v.cout});
        check("ovf8", {31'd0, ovf8}, {31'd0, v.ovf});
        check("busy8_at_done", {31'd0, busy8}, 32'd0);
        repeat (2) @(negedge clk);
        check("hold_out8", {24'd0, out8}, {24'd0, v.out});
        check("hold_done8", {31'd0, done8}, 32'd1);
    endtask

    task automatic run16(input logic s, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] e_out, input logic e_cout, input logic e_ovf);
        int lat, busy_cnt;
        @(negedge clk);
        en16 = 1'b1; sub16 = s; a16 = x; b16 = y;
        lat = 0; busy_cnt = 0;
        do begin
            @(negedge clk);
            lat++;
            en16 = 1'b0;
            a16  = 16'($urandom);
            b16  = 16'($urandom);
            if (busy16) busy_cnt++;
        end while (!done16 && lat < 40);
        $display("w16: sub=%0b a=%04h b=%04h -> out=%04h cout=%0b ovf=%0b lat=%0d busy=%0d",
                 s, x, y, out16, cout16, ovf16, lat, busy_cnt);
        check("lat16", lat, 5);
        check("busy16_cycles", busy_cnt, 4);
        check("out16", {16'd0, out16}, {16'd0, e_out});
        check("cout16", {31'd0, cout16}, {31'd0, e_cout});
        check("ovf16", {31'd0, ovf16}, {31'd0, e_ovf});
    endtask

    task automatic run1(input logic s, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] e_out, input logic e_cout, input logic e_ovf);
        int lat;
        @(negedge clk);
        en1 = 1'b1; sub1 = s; a1 = x; b1 = y;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            en1 = 1'b0;
            a1  = 8'($urandom);
            b1  = 8'($urandom);
        end while (!done1 && lat < 40);
        $display("n1: sub=%0b a=%02h b=%02h -> out=%02h cout=%0b ovf=%0b lat=%0d",
                 s, x, y, out1, cout1, ovf1, lat);
        check("lat1", lat, 2);
        check("out1", {24'd0, out1}, {24'd0, e_out});
        check("cout1", {31'd0, cout1}, {31'd0, e_cout});
        check("ovf1", {31'd0, ovf1}, {31'd0, e_ovf});
    endtask

    initial begin
        int lat;

        //          sub   a      b      noise  out    cout  ovf
        vecs[0] = '{1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 8'h01, 8'h02, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_out8", {24'd0, out8}, 32'd0);
        check("rst_flags8", {28'd0, cout8, ovf8, busy8, done8}, 32'd0);
        check("rst_out16", {16'd0, out16}, 32'd0);
        check("rst_flags16", {28'd0, cout16, ovf16, busy16, done16}, 32'd0);
        check("rst_flags1", {28'd0, cout1, ovf1, busy1, done1}, 32'd0);

        // Table-driven operations on the 8-bit serial instance
        for (int i = 0; i < 9; i++) begin
            run8(i, vecs[i]);
        end

        // Wider slices and the single-cycle configuration
        run16(1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0);
        run16(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
        run1(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
        run1(1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1);

        // Reset during the third ADD cycle discards the operation
        @(negedge clk);
        en8 = 1'b1; sub8 = 1'b0; a8 = 8'h5A; b8 = 8'h3C;
        @(negedge clk); en8 = 1'b0;   // accepted
        @(negedge clk);               // ADD cycle 1 done
        @(negedge clk);               // ADD cycle 2 done
        rst = 1'b1;                   // sampled at end of ADD cycle 3
        @(negedge clk);
        rst = 1'b0;
        $display("reset mid-ADD: out=%02h busy=%0b done=%0b", out8, busy8, done8);
        check("midrst_out8", {24'd0, out8}, 32'd0);
        check("midrst_busy8", {31'd0, busy8}, 32'd0);
        check("midrst_done8", {31'd0, done8}, 32'd0);
        check("midrst_flags8", {30'd0, cout8, ovf8}, 32'd0);
        run8(9, vecs[0]);

        // Back-to-back: en held high from DONE, no IDLE bubble
        @(negedge clk);
        en8 = 1'b1; sub8 = 1'b0; a8 = 8'h01; b8 = 8'h02;
        @(negedge clk);
        check("b2b_busy_immediate", {30'd0, busy8, done8}, 32'd2);
        lat = 1;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        $display("b2b op1: out=%02h lat=%0d", out8, lat);
        check("b2b_lat1", lat, 9);
        check("b2b_out1", {24'd0, out8}, 32'h03);
        a8 = 8'h30; b8 = 8'h05;       // en still high: accepted at next edge
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done8 && lat < 40);
        en8 = 1'b0;
        $display("b2b op2: out=%02h period=%0d", out8, lat);
        check("b2b_period", lat, 9);
        check("b2b_out2", {24'd0, out8}, 32'h35);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_add_sub_serial_param
